// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the sync_fifo slice.
//   ptr_width()   - pointer width for a given depth
//   level_width() - width of the occupancy count (must hold 0..DEPTH)
//   params_ok()   - parameter legality check used at elaboration
//   fifo_status_t - packed status bundle for wrappers
package fifo_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int ptr_width(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  function automatic bit params_ok(input int depth, input int afull_th, input int aempty_th);
    bit pow2;
    bit af_ok;
    bit ae_ok;
    pow2  = (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
    af_ok = (afull_th >= 32'sd1) && (afull_th <= depth);
    ae_ok = (aempty_th >= 32'sd0) && (aempty_th <= depth - 32'sd1);
    return pow2 && af_ok && ae_ok;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer handshake bundle for sync_fifo.
//   master modport: drives flush, wr_en, data_in, rd_en; observes data and status.
//   slave  modport: the FIFO side, drives data_out, level and all status flags.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int LW = level_width(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, empty, full, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, empty, full, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x WIDTH register array.
//   clk     - write clock
//   wr_en   - write strobe, stores wr_data at wr_addr
//   rd_addr - asynchronous read address, rd_data follows it combinationally
// Contents are intentionally not reset; the FIFO never exposes unwritten words.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with thresholds, live level, sticky errors and flush.
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - sync_fifo_if.slave: flush/wr_en/data_in/rd_en in;
//           data_out, empty, full, almost_full, almost_empty, level,
//           overflow, underflow out
// FWFT=0 gives a registered read (data one cycle after rd_en); FWFT=1 shows
// the head word whenever the FIFO is not empty and rd_en pops it.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input logic       clk,
  input logic       rst_n,
  sync_fifo_if.slave bus
);
  localparam int AW = ptr_width(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL  = LW'(AFULL_TH);
  localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_TH);
  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);

  if (!params_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_param_err
    $error("sync_fifo: DEPTH must be a power of two >= 2 and thresholds in range");
  end

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_nxt_s;
  logic             empty_r;
  logic             full_r;
  logic             afull_r;
  logic             aempty_r;
  logic             ovf_r;
  logic             udf_r;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic [WIDTH-1:0] rd_data_s;

  // Acceptance from registered flags only; flush masks both requests.
  always_comb begin
    wr_acc_s    = 1'b0;
    rd_acc_s    = 1'b0;
    level_nxt_s = level_r;
    if (bus.flush) begin
      level_nxt_s = {LW{1'b0}};
    end else begin
      wr_acc_s = bus.wr_en && !full_r;
      rd_acc_s = bus.rd_en && !empty_r;
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_nxt_s = level_r + LW'(1'b1);
        2'b01:   level_nxt_s = level_r - LW'(1'b1);
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Pointers, level, status flags and sticky errors.
  // Flags are registered from the next level so they always match level_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      level_r  <= level_nxt_s;
      empty_r  <= (level_nxt_s == {LW{1'b0}});
      full_r   <= (level_nxt_s == FULL_LVL);
      afull_r  <= (level_nxt_s >= AFULL_LVL);
      aempty_r <= (level_nxt_s <= AEMPTY_LVL);
      if (bus.flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        ovf_r    <= 1'b0;
        udf_r    <= 1'b0;
      end else begin
        if (wr_acc_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
        if (rd_acc_s) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
        if (bus.wr_en && full_r)  ovf_r <= 1'b1;
        if (bus.rd_en && empty_r) udf_r <= 1'b1;
      end
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so reset reads 0.
    assign bus.data_out = empty_r ? {WIDTH{1'b0}} : rd_data_s;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_r;

    // Output register loads only on an accepted read, so it holds across flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_r <= {WIDTH{1'b0}};
      end else if (rd_acc_s) begin
        dout_r <= rd_data_s;
      end
    end

    assign bus.data_out = dout_r;
  end

  assign bus.level        = level_r;
  assign bus.empty        = empty_r;
  assign bus.full         = full_r;
  assign bus.almost_full  = afull_r;
  assign bus.almost_empty = aempty_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = udf_r;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo in both output modes.
// dut0 is FWFT=0, dut1 is FWFT=1. Written words are queued as they are issued;
// per-instance monitors pop and compare whenever a read delivers a word.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic pend0 = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(8), .DEPTH(16)) bus0 ();
  sync_fifo_if #(.WIDTH(8), .DEPTH(16)) bus1 ();

  sync_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic fifo_status_t st0();
    return {bus0.empty, bus0.full, bus0.almost_full, bus0.almost_empty, bus0.overflow, bus0.underflow};
  endfunction

  function automatic fifo_status_t st1();
    return {bus1.empty, bus1.full, bus1.almost_full, bus1.almost_empty, bus1.overflow, bus1.underflow};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [7:0] d, input bit accept);
    bus0.wr_en   = 1'b1;
    bus0.data_in = d;
    if (accept) q0.push_back(d);
    cyc();
    bus0.wr_en = 1'b0;
  endtask

  task automatic rd0();
    bus0.rd_en = 1'b1;
    cyc();
    bus0.rd_en = 1'b0;
  endtask

  task automatic wr1(input logic [7:0] d);
    bus1.wr_en   = 1'b1;
    bus1.data_in = d;
    q1.push_back(d);
    cyc();
    bus1.wr_en = 1'b0;
  endtask

  task automatic rd1();
    bus1.rd_en = 1'b1;
    cyc();
    bus1.rd_en = 1'b0;
  endtask

  // Registered-read monitor: a read accepted at an edge is compared at the next falling edge.
  always @(negedge clk) begin
    if (pend0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb0_queue actual=0x%0h required=nonempty", bus0.data_out);
      end else begin
        chk("sb0_data", 32'(bus0.data_out), 32'(q0.pop_front()));
      end
    end
    pend0 = rst_n && bus0.rd_en && !bus0.empty && !bus0.flush;
  end

  // FWFT monitor: the displayed word is compared when it is popped.
  always @(negedge clk) begin
    if (rst_n && bus1.rd_en && !bus1.empty && !bus1.flush) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_queue actual=0x%0h required=nonempty", bus1.data_out);
      end else begin
        chk("sb1_data", 32'(bus1.data_out), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus0.flush = 1'b0; bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.data_in = 8'h00;
    bus1.flush = 1'b0; bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.data_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Reset state
    chk("rst_st0",   32'(st0()), 32'(6'b100100));
    chk("rst_lvl0",  32'(bus0.level), 32'd0);
    chk("rst_dout0", 32'(bus0.data_out), 32'h00);
    chk("rst_st1",   32'(st1()), 32'(6'b100100));
    chk("rst_dout1", 32'(bus1.data_out), 32'h00);

    // Fill 0x00..0x0F, then overflow with 0xAA
    for (int i = 0; i < 16; i++) begin
      wr0(8'(i), 1'b1);
      chk("fill_lvl", 32'(bus0.level), 32'(i + 1));
      chk("fill_st", 32'(st0()), 32'({1'b0, (i == 15), (i >= 13), (i <= 1), 1'b0, 1'b0}));
    end
    wr0(8'hAA, 1'b0);
    chk("ovf_lvl", 32'(bus0.level), 32'd16);
    chk("ovf_st",  32'(st0()), 32'(6'b011010));
    bus0.rd_en = 1'b1;
    repeat (16) cyc();
    bus0.rd_en = 1'b0;
    cyc();
    chk("drain_st",  32'(st0()), 32'(6'b100110));
    chk("drain_lvl", 32'(bus0.level), 32'd0);
    bus0.flush = 1'b1;
    cyc();
    bus0.flush = 1'b0;
    chk("flush1_st", 32'(st0()), 32'(6'b100100));

    // Registered-read latency and underflow hold
    wr0(8'hA5, 1'b1);
    wr0(8'h5A, 1'b1);
    wr0(8'h3C, 1'b1);
    rd0(); chk("rd_a5", 32'(bus0.data_out), 32'hA5);
    rd0(); chk("rd_5a", 32'(bus0.data_out), 32'h5A);
    rd0(); chk("rd_3c", 32'(bus0.data_out), 32'h3C);
    rd0();
    chk("udf_st",   32'(st0()), 32'(6'b100101));
    chk("udf_hold", 32'(bus0.data_out), 32'h3C);
    bus0.flush = 1'b1;
    cyc();
    bus0.flush = 1'b0;

    // Level 8, 20 cycles of simultaneous read/write wrapping the pointers
    for (int i = 0; i < 8; i++) wr0(8'(8'h10 + i), 1'b1);
    chk("half_lvl", 32'(bus0.level), 32'd8);
    bus0.wr_en = 1'b1;
    bus0.rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus0.data_in = 8'(8'h18 + i);
      q0.push_back(bus0.data_in);
      cyc();
      chk("rw_lvl", 32'(bus0.level), 32'd8);
    end
    bus0.wr_en = 1'b0;
    chk("rw_st", 32'(st0()), 32'(6'b000000));
    repeat (8) cyc();
    bus0.rd_en = 1'b0;
    cyc();
    chk("rw_end_st", 32'(st0()), 32'(6'b100100));

    // Level 5 with overflow set, then flush together with a write
    for (int i = 0; i < 16; i++) wr0(8'(8'h70 + i), 1'b1);
    wr0(8'hAA, 1'b0);
    bus0.rd_en = 1'b1;
    repeat (11) cyc();
    bus0.rd_en = 1'b0;
    cyc();
    chk("pre_flush_lvl", 32'(bus0.level), 32'd5);
    chk("pre_flush_st",  32'(st0()), 32'(6'b000010));
    q0.delete();
    bus0.flush   = 1'b1;
    bus0.wr_en   = 1'b1;
    bus0.data_in = 8'hEE;
    cyc();
    bus0.flush = 1'b0;
    bus0.wr_en = 1'b0;
    chk("flush_lvl",  32'(bus0.level), 32'd0);
    chk("flush_st",   32'(st0()), 32'(6'b100100));
    chk("flush_dout", 32'(bus0.data_out), 32'h7A);

    // Read and write together while empty: write wins, underflow set
    bus0.wr_en   = 1'b1;
    bus0.rd_en   = 1'b1;
    bus0.data_in = 8'h33;
    q0.push_back(8'h33);
    cyc();
    bus0.wr_en = 1'b0;
    bus0.rd_en = 1'b0;
    chk("mirror_lvl", 32'(bus0.level), 32'd1);
    chk("mirror_st",  32'(st0()), 32'(6'b000101));
    rd0();
    chk("mirror_rd", 32'(bus0.data_out), 32'h33);

    // Asynchronous reset mid-operation, first write right after release
    wr0(8'h01, 1'b1);
    wr0(8'h02, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lvl",  32'(bus0.level), 32'd0);
    chk("arst_st",   32'(st0()), 32'(6'b100100));
    chk("arst_dout", 32'(bus0.data_out), 32'h00);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wr0(8'h55, 1'b1);
    chk("post_rst_lvl", 32'(bus0.level), 32'd1);
    rd0();
    cyc();

    // FWFT: word visible as soon as empty falls, pop empties it
    wr1(8'h42);
    chk("fwft_st",   32'(st1()), 32'(6'b000100));
    chk("fwft_dout", 32'(bus1.data_out), 32'h42);
    chk("fwft_lvl",  32'(bus1.level), 32'd1);
    rd1();
    chk("fwft_pop_st",  32'(st1()), 32'(6'b100100));
    chk("fwft_pop_lvl", 32'(bus1.level), 32'd0);
    wr1(8'h11);
    wr1(8'h22);
    chk("fwft_head", 32'(bus1.data_out), 32'h11);
    rd1();
    chk("fwft_next", 32'(bus1.data_out), 32'h22);
    rd1();
    rd1();
    chk("fwft_udf_st", 32'(st1()), 32'(6'b100101));

    cyc();
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
